sipo_rx: RTL and testbench
==========================

Name: sipo_rx

Overview:
- Serial-in/parallel-out receiver: the receive-side counterpart of the team's parallel-to-serial shift register.
- Samples one bit per qualified clock from a serial link and assembles WIDTH-bit words, optionally with parity.
- Presents each completed word on a one-entry valid/ready output buffer.
- Sits at the serial ingress of a datapath, feeding parallel consumers.

Parameters:
- WIDTH, 4, data bits per word (2 to 32).
- MSB_FIRST, 1, 1 = first received bit lands in m_data[WIDTH-1]; 0 = first bit lands in m_data[0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- s_in  input  1  serial data bit.
- s_valid  input  1  s_in is sampled this cycle.
- s_sync  input  1  word-boundary marker; with s_valid, this bit is bit 0 of a new word.
- m_data  output  WIDTH  assembled word.
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  consumer accepts m_data when m_valid & m_ready.
- overflow  output  1  sticky: a completed word was dropped.
- clr_ovf  input  1  clears overflow.
- parity_err  output  1  parity error on the current m_data word; tied 0 when the feature is off.

Behaviour:
- Reset (rst_n=0 at a clk edge): bit counter=0, shift reg=0, m_data=0, m_valid=0, overflow=0, parity_err=0. Reset mid-word discards the partial word.
- Clock is one domain; reset is synchronous and active-low.
- States: SHIFT (collecting bits, count 0..FRAME-1) and implicit buffer FULL/EMPTY.
  - FRAME = WIDTH, or WIDTH+1 with the parity feature.
- Each cycle with s_valid=1:
  - If s_sync=1, the counter restarts: the bit is stored as bit 0 of a new word and any partial word is discarded without an error flag.
  - Otherwise the bit shifts in and the counter increments.
- Bit order: with MSB_FIRST=1 the shift is left, new bit entering at LSB, so the first bit ends at MSB. With MSB_FIRST=0 the shift is right, new bit entering at MSB.
- s_valid=0: shift reg and counter hold.
- Word completion: the cycle the FRAME-th bit is sampled.
  - The word is written to m_data and m_valid=1 on the next edge (1-cycle latency from last bit to m_valid).
  - The counter returns to 0.
- Pop: m_valid & m_ready at an edge clears m_valid unless a word completes in the same cycle.
  - Simultaneous pop and completion: the new word loads, m_valid stays 1, no overflow.
- Overflow: a word completes while m_valid=1 and m_ready=0.
  - The new word is dropped, m_data is unchanged, overflow is set.
- overflow clears only on clr_ovf=1. If clr_ovf=1 and a new overflow occur in the same cycle, set wins.
- m_data is stable while m_valid=1 and m_ready=0.
- The counter wraps only via completion or s_sync; it never exceeds FRAME-1.

Optional Feature:
- Macro: SIPO_RX_PARITY_CHECK_EN.
- Defined:
  - FRAME=WIDTH+1; the last bit of each frame is an even-parity bit over the data bits.
  - parity_err is computed as XOR of data bits and the parity bit.
  - parity_err loads with m_data and is valid while m_valid=1.
  - The word is delivered even on error.
- Undefined: FRAME=WIDTH, parity_err tied 0, no parity logic.

Decomposition:
- Package sipo_rx_pkg holds:
  - localparam FRAME derivation;
  - counter width function CNT_W = clog2(FRAME);
  - an enum for the shift direction.
- One sub-module, sipo_shift_core: shift register, bit counter, s_sync handling, word_done pulse.
- Top-level sipo_rx holds the output buffer, overflow and parity logic.

Test Plan:
- Basic word: WIDTH=4, MSB_FIRST=1, send bits 1,0,1,1 with s_valid=1 and s_sync on the first bit, m_ready=1 -> m_data=4'hB, m_valid=1 for 1 cycle, 1 cycle after the last bit.
- Gapped input and LSB-first: MSB_FIRST=0, bits 1,0,0,0 with s_valid low for 2 cycles between bits -> m_data=4'h1; no change while s_valid=0.
- Backpressure and overflow: m_ready=0, send 2 full words 4'hA then 4'h5 -> m_data stays 4'hA and overflow=1; then clr_ovf=1 -> overflow=0, m_data still 4'hA.
- Simultaneous pop and completion: m_valid=1 with 4'h3, m_ready=1 on the cycle word 4'hC completes -> next cycle m_data=4'hC, m_valid=1, overflow=0.
- Resync and reset: s_sync after 2 bits of a word, then 4 bits 0,1,1,0 -> m_data=4'h6. Separately, rst_n=0 after 3 bits -> next word needs 4 fresh bits and all outputs read 0.
- Parity (macro defined): data 1,0,1,1 with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1, m_data=4'hB.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the sipo_rx serial receiver.
// Frame length grows by one parity bit when SIPO_RX_PARITY_CHECK_EN is defined.
package sipo_rx_pkg;

`ifdef SIPO_RX_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_e;

    function automatic int frame_len(input int width);
        return PARITY_EN ? width + 1 : width;
    endfunction

    function automatic int cnt_w(input int frame);
        return (frame < 2) ? 1 : $clog2(frame);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for sipo_rx: assembles FRAME bits and
// pulses word_done_o combinationally in the cycle the last bit is sampled.
module sipo_shift_core
    import sipo_rx_pkg::*;
#(
    parameter int         FRAME = 4,
    parameter shift_dir_e DIR   = SHIFT_LEFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in_i,
    input  logic             s_valid_i,
    input  logic             s_sync_i,
    output logic [FRAME-1:0] frame_o,
    output logic             word_done_o
);

    localparam int             CW   = cnt_w(FRAME);
    localparam logic [CW-1:0]  LAST = CW'(FRAME - 1);

    logic [FRAME-1:0] sreg_q, sreg_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;

    // A sync bit starts a fresh word, so the old contents are zeroed rather than shifted.
    always_comb begin
        shifted = sreg_q;
        if (DIR == SHIFT_LEFT)
            shifted = s_sync_i ? {{(FRAME-1){1'b0}}, s_in_i} : {sreg_q[FRAME-2:0], s_in_i};
        else
            shifted = s_sync_i ? {s_in_i, {(FRAME-1){1'b0}}} : {s_in_i, sreg_q[FRAME-1:1]};
    end

    always_comb begin
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        word_done_o = 1'b0;
        if (s_valid_i) begin
            sreg_d = shifted;
            if (s_sync_i) begin
                cnt_d = CW'(1);
            end else if (cnt_q == LAST) begin
                cnt_d       = '0;
                word_done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign frame_o = shifted;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver with a one-entry valid/ready output buffer
// and sticky overflow. Parity checking is enabled by SIPO_RX_PARITY_CHECK_EN.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_sync,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic             parity_err
);

    localparam int FRAME = frame_len(WIDTH);

    logic [FRAME-1:0] frame_w;
    logic [WIDTH-1:0] data_w;
    logic             word_done;
    logic             load, ovf_set;

    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             ovf_q, ovf_d;

    sipo_shift_core #(
        .FRAME (FRAME),
        .DIR   (MSB_FIRST ? SHIFT_LEFT : SHIFT_RIGHT)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_in_i      (s_in),
        .s_valid_i   (s_valid),
        .s_sync_i    (s_sync),
        .frame_o     (frame_w),
        .word_done_o (word_done)
    );

    // Data bits are the first WIDTH bits received; a trailing parity bit sits at the far end.
    generate
        if (MSB_FIRST) begin : g_msb
            assign data_w = frame_w[FRAME-1 -: WIDTH];
        end else begin : g_lsb
            assign data_w = frame_w[WIDTH-1:0];
        end
    endgenerate

    assign load    = word_done & (~m_valid_q | m_ready);
    assign ovf_set = word_done & m_valid_q & ~m_ready;

    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (load) begin
            m_data_d  = data_w;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        ovf_d = ovf_set | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef SIPO_RX_PARITY_CHECK_EN
    logic perr_q, perr_d;

    // Even parity: XOR over data and parity bits is 0 for a good frame.
    assign perr_d = load ? ^frame_w : perr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: an MSB-first and an LSB-first instance share one serial stream.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst_n, s_in, s_valid, s_sync, m_ready, clr_ovf;
    logic [3:0] m_data, m_data_l;
    logic       m_valid, m_valid_l, overflow, overflow_l, parity_err, parity_err_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .s_sync(s_sync),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .overflow(overflow), .clr_ovf(clr_ovf), .parity_err(parity_err)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .s_sync(s_sync),
        .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready),
        .overflow(overflow_l), .clr_ovf(clr_ovf), .parity_err(parity_err_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sync);
        s_in    = b;
        s_sync  = sync;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sync  = 1'b0;
        s_in    = 1'b0;
    endtask

    // Appends the even-parity bit when the parity build is in use.
    task automatic finish_word(input logic [3:0] d);
`ifdef SIPO_RX_PARITY_CHECK_EN
        send_bit(^d, 1'b0);
`else
        if (d === 4'hx) $display("bad word");
`endif
    endtask

    task automatic send_word(input logic [3:0] d, input logic sync);
        send_bit(d[3], sync);
        send_bit(d[2], 1'b0);
        send_bit(d[1], 1'b0);
        send_bit(d[0], 1'b0);
        finish_word(d);
    endtask

    initial begin
        rst_n = 1'b0; s_in = 1'b0; s_valid = 1'b0; s_sync = 1'b0;
        m_ready = 1'b0; clr_ovf = 1'b0;
        idle(2);
        chk("rst_data", m_data, 4'h0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        rst_n = 1'b1;

        // basic word 1,0,1,1
        m_ready = 1'b1;
        send_word(4'hB, 1'b1);
        chk("basic_data", m_data, 4'hB);
        chk("basic_valid", m_valid, 1'b1);
        chk("basic_lsb_data", m_data_l, 4'hD);
        chk("basic_perr", parity_err, 1'b0);
        idle(1);
        chk("basic_pop", m_valid, 1'b0);

        // gapped 1,0,0,0
        send_bit(1'b1, 1'b1);
        idle(2);
        chk("gap_hold_valid", m_valid_l, 1'b0);
        chk("gap_hold_data", m_data_l, 4'hD);
        send_bit(1'b0, 1'b0); idle(2);
        send_bit(1'b0, 1'b0); idle(2);
        send_bit(1'b0, 1'b0);
        finish_word(4'h8);
        chk("gap_lsb_data", m_data_l, 4'h1);
        chk("gap_lsb_valid", m_valid_l, 1'b1);
        chk("gap_msb_data", m_data, 4'h8);
        idle(1);

        // backpressure and overflow
        m_ready = 1'b0;
        send_word(4'hA, 1'b1);
        chk("bp_first", m_data, 4'hA);
        chk("bp_no_ovf", overflow, 1'b0);
        send_word(4'h5, 1'b0);
        chk("ovf_data_hold", m_data, 4'hA);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_valid", m_valid, 1'b1);
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
        chk("ovf_clr_data", m_data, 4'hA);
        clr_ovf = 1'b1;
        send_word(4'hF, 1'b0);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", overflow, 1'b1);
        chk("ovf_set_wins_data", m_data, 4'hA);
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        m_ready = 1'b1; idle(1); m_ready = 1'b0;
        chk("bp_pop", m_valid, 1'b0);

        // simultaneous pop and completion
        send_word(4'h3, 1'b1);
        chk("sim_first", m_data, 4'h3);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
`ifdef SIPO_RX_PARITY_CHECK_EN
        send_bit(1'b0, 1'b0);
        m_ready = 1'b1;
        send_bit(1'b0, 1'b0);
`else
        m_ready = 1'b1;
        send_bit(1'b0, 1'b0);
`endif
        chk("sim_data", m_data, 4'hC);
        chk("sim_valid", m_valid, 1'b1);
        chk("sim_ovf", overflow, 1'b0);
        idle(1);
        chk("sim_pop", m_valid, 1'b0);

        // resync after two bits
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("resync_partial", m_valid, 1'b0);
        send_word(4'h6, 1'b1);
        chk("resync_data", m_data, 4'h6);
        chk("resync_valid", m_valid, 1'b1);
        idle(1);

        // reset mid-word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        chk("mrst_data", m_data, 4'h0);
        chk("mrst_valid", m_valid, 1'b0);
        chk("mrst_lsb_data", m_data_l, 4'h0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("mrst_three_bits", m_valid, 1'b0);
        send_bit(1'b1, 1'b0);
        finish_word(4'hB);
        chk("mrst_word", m_data, 4'hB);
        chk("mrst_word_valid", m_valid, 1'b1);
        idle(1);

`ifdef SIPO_RX_PARITY_CHECK_EN
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk("par_ok", parity_err, 1'b0);
        chk("par_ok_data", m_data, 4'hB);
        idle(1);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        chk("par_err", parity_err, 1'b1);
        chk("par_err_data", m_data, 4'hB);
        chk("par_err_valid", m_valid, 1'b1);
        idle(1);
`else
        chk("par_off", parity_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
